// File: rtl/fir_tap_feeder.sv
// Four-tap sample window and weight register bank feeding a downstream
// two-register multiply/add tree, with valid tracking that matches its latency.
module fir_tap_feeder #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rest,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic           in_ready,
  input  logic           coef_we,
  input  logic [1:0]     coef_addr,
  input  logic [W-1:0]   coef_data,
  input  logic           flush,
  output logic [4*W-1:0] win_data,
  output logic [4*W-1:0] win_weights,
  output logic           win_valid,
  output logic           sum_valid,
  output logic [2:0]     fill_cnt
);

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t              r_state;
  logic [3:0][W-1:0]   r_taps;
  logic [3:0][W-1:0]   r_weights;
  logic [2:0]          r_fill_cnt;
  logic                r_win_valid;
  logic [1:0]          r_sum_pipe;

  logic                w_accept;
  logic                w_window_full;
  logic [2:0]          w_fill_next;

  // Weight writes and resets take the cycle, so no sample can be accepted in it.
  assign in_ready      = !rest && !flush && !coef_we;
  assign w_accept      = in_valid && in_ready;
  assign w_fill_next   = (r_fill_cnt == 3'd4) ? 3'd4 : r_fill_cnt + 3'd1;
  assign w_window_full = (r_state == S_RUN) || (r_fill_cnt == 3'd3);

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, exactly like the flops they describe.
  always_ff @(posedge clk) begin
    if (rest) begin
      // NOTE: the weight bank is reset as well; downstream must never see
      // stale weights after reset, and it is only four words.
      r_state     <= S_FILL;
      r_taps      <= '0;
      r_weights   <= '0;
      r_fill_cnt  <= '0;
      r_win_valid <= 1'b0;
      r_sum_pipe  <= '0;
    end else if (flush) begin
      r_state     <= S_FILL;
      r_taps      <= '0;
      r_fill_cnt  <= '0;
      r_win_valid <= 1'b0;
      r_sum_pipe  <= '0;
    end else begin
      r_sum_pipe  <= {r_sum_pipe[0], r_win_valid};
      r_win_valid <= w_accept && w_window_full;
      if (coef_we) begin
        r_weights[coef_addr] <= coef_data;
      end else if (w_accept) begin
        r_taps     <= {r_taps[2:0], in_data};
        r_fill_cnt <= w_fill_next;
        if (w_fill_next == 3'd4) r_state <= S_RUN;
      end
    end
  end

  assign win_data    = r_taps;
  assign win_weights = r_weights;
  assign win_valid   = r_win_valid;
  assign sum_valid   = r_sum_pipe[1];
  assign fill_cnt    = r_fill_cnt;

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Directed bench for fir_tap_feeder: weights, streaming, saturation, coef/flush/reset
// priority and the two-cycle sum_valid delay, with hand-computed expectations.
module tb_fir_tap_feeder;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rest;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic           coef_we;
  logic [1:0]     coef_addr;
  logic [W-1:0]   coef_data;
  logic           flush;
  logic [4*W-1:0] win_data;
  logic [4*W-1:0] win_weights;
  logic           win_valid;
  logic           sum_valid;
  logic [2:0]     fill_cnt;

  int n_cmp = 0;
  int n_err = 0;

  fir_tap_feeder #(.W(W)) dut (
    .clk(clk), .rest(rest), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .flush(flush), .win_data(win_data),
    .win_weights(win_weights), .win_valid(win_valid), .sum_valid(sum_valid),
    .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rest = 1'b0; in_valid = 1'b0; in_data = '0; coef_we = 1'b0;
    coef_addr = '0; coef_data = '0; flush = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [63:0] pack4(input int t3, input int t2, input int t1, input int t0);
    return {t3[15:0], t2[15:0], t1[15:0], t0[15:0]};
  endfunction

  initial begin
    int dot;
    logic exp_wv, exp_p0, exp_p1;
    int n_acc, n_pulse;

    // Reset
    idle();
    rest = 1'b1;
    #1;
    check("ready_in_reset", in_ready, 0);
    step(); step();
    check("rst_fill", fill_cnt, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_win_data", win_data, 0);
    check("rst_weights", win_weights, 0);
    rest = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);

    // Weights 1..4
    for (int i = 0; i < 4; i++) begin
      coef_we = 1'b1; coef_addr = 2'(i); coef_data = 16'(i + 1);
      step();
    end
    coef_we = 1'b0;
    check("weights_1234", win_weights, pack4(4, 3, 2, 1));
    check("fill_after_wr", fill_cnt, 0);

    // Stream 10,20,30,40
    push(16'd10); push(16'd20); push(16'd30);
    check("fill_3", fill_cnt, 3);
    check("wv_before_full", win_valid, 0);
    push(16'd40);
    check("wv_full", win_valid, 1);
    check("fill_4", fill_cnt, 4);
    check("win_10_20_30_40", win_data, pack4(10, 20, 30, 40));
    dot = 0;
    for (int k = 0; k < 4; k++)
      dot += int'(win_data[k*W +: W]) * int'(win_weights[k*W +: W]);
    check("dot_200", 64'(dot), 200);
    step();
    check("wv_single_pulse", win_valid, 0);
    check("sum_not_yet", sum_valid, 0);
    step();
    check("sum_2_later", sum_valid, 1);
    step();
    check("sum_pulse_end", sum_valid, 0);

    // Continue with 50, saturation
    push(16'd50);
    check("wv_run", win_valid, 1);
    check("win_after_50", win_data, pack4(20, 30, 40, 50));
    check("fill_sat", fill_cnt, 4);

    // Sample and weight write in the same cycle
    in_valid = 1'b1; in_data = 16'd99;
    coef_we = 1'b1; coef_addr = 2'd2; coef_data = 16'd7;
    #1;
    check("ready_coef_we", in_ready, 0);
    step();
    idle();
    check("coef_no_accept", win_data, pack4(20, 30, 40, 50));
    check("coef_wv", win_valid, 0);
    check("coef_fill", fill_cnt, 4);
    check("coef_weight", win_weights, pack4(4, 7, 2, 1));
    step();
    check("sum_through_coef", sum_valid, 1);

    // Flush with full window, then 2 samples, then flush again with in_valid high
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_fill", fill_cnt, 0);
    check("flush_taps", win_data, 0);
    check("flush_keep_w", win_weights, pack4(4, 7, 2, 1));
    push(16'd5); push(16'd6);
    check("fill_2", fill_cnt, 2);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'd77;
    #1;
    check("ready_flush", in_ready, 0);
    step();
    idle();
    check("flush2_fill", fill_cnt, 0);
    push(16'd1); push(16'd2); push(16'd3);
    check("refill_no_wv", win_valid, 0);
    push(16'd4);
    check("refill_wv", win_valid, 1);
    check("refill_win", win_data, pack4(1, 2, 3, 4));
    // Flush right after a pulse cancels its sum_valid
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_wv", win_valid, 0);
    step();
    check("flush_sum_a", sum_valid, 0);
    step();
    check("flush_sum_b", sum_valid, 0);

    // Reset one cycle after a pulse
    push(16'd9); push(16'd8); push(16'd7); push(16'd6);
    check("pre_rst_wv", win_valid, 1);
    rest = 1'b1; step(); rest = 1'b0;
    check("rst2_data", win_data, 0);
    check("rst2_w", win_weights, 0);
    check("rst2_fill", fill_cnt, 0);
    check("rst2_wv", win_valid, 0);
    check("rst2_sum", sum_valid, 0);
    // First accept in the first cycle out of reset
    push(16'h11);
    check("first_acc_fill", fill_cnt, 1);
    check("first_acc_tap0", win_data, 64'h11);
    check("rst2_sum_b", sum_valid, 0);
    step();
    check("rst2_sum_c", sum_valid, 0);

    // Gapped stream of 6 samples with a small valid-pipeline model
    flush = 1'b1; step(); flush = 1'b0;
    exp_wv = 0; exp_p0 = 0; exp_p1 = 0; n_acc = 0; n_pulse = 0;
    for (int k = 0; k < 14; k++) begin
      in_valid = (k % 2 == 0) && (n_acc < 6);
      in_data  = 16'(16'h100 + n_acc + 1);
      step();
      exp_p1 = exp_p0;
      exp_p0 = exp_wv;
      if (in_valid) n_acc++;
      exp_wv = in_valid && (n_acc >= 4);
      if (win_valid) n_pulse++;
      check($sformatf("gap_wv_%0d", k), win_valid, exp_wv);
      check($sformatf("gap_sum_%0d", k), sum_valid, exp_p1);
    end
    idle();
    check("gap_pulses", n_pulse, 3);
    check("gap_win", win_data, pack4(16'h103, 16'h104, 16'h105, 16'h106));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fir_tap_feeder.md
FIR_TAP_FEEDER -- requirements
Module: fir_tap_feeder

Interface
REQ-001 Parameter W, default 16: width of one sample and one weight.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rest  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 in_valid  input  1  upstream sample present on in_data.
REQ-005 in_data  input  W  incoming sample.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 coef_we  input  1  weight write strobe.
REQ-008 coef_addr  input  2  weight index 0..3.
REQ-009 coef_data  input  W  weight value.
REQ-010 flush  input  1  discard window contents and restart fill.
REQ-011 win_data  output  4W  tap window {tap3,tap2,tap1,tap0}, tap0 in bits [W-1:0]; drives the downstream summation data inputs.
REQ-012 win_weights  output  4W  {w3,w2,w1,w0}, w0 in bits [W-1:0]; drives the downstream summation weight inputs.
REQ-013 win_valid  output  1  win_data holds a full 4-sample window, new this cycle.
REQ-014 sum_valid  output  1  downstream 2-register summation output corresponds to a valid window this cycle.
REQ-015 fill_cnt  output  3  number of samples held, 0..4.

Function
REQ-016 Accept = in_valid & in_ready; in_ready = !rest & !flush & !coef_we (combinational).
REQ-017 On accept: tap0 <= in_data, tap(k) <= tap(k-1) for k=1..3; tap3 is discarded.
REQ-018 fill_cnt increments by 1 on accept, saturates at 4; no wrap-around to 0.
REQ-019 FSM states FILL (fill_cnt<4) and RUN (fill_cnt=4); FILL->RUN on the accept taking fill_cnt to 4; RUN->FILL only on flush or rest.
REQ-020 win_valid registered: 1 in the cycle after an accept that leaves fill_cnt=4, else 0; a single-cycle pulse per accepted sample in RUN.
REQ-021 Taps hold their value when no accept occurs; win_valid then 0.
REQ-022 sum_valid = win_valid delayed exactly 2 clk cycles via a 2-stage shift register, matching the downstream multiply->reg->add->reg->add latency.
REQ-023 coef_we=1: weight[coef_addr] <= coef_data at next edge; visible on win_weights the following cycle; no sample accepted that cycle.
REQ-024 Weight writes never change taps, fill_cnt or the sum_valid pipeline.
REQ-025 flush=1: all taps <= 0, fill_cnt <= 0, state <= FILL, win_valid <= 0, both sum_valid stages <= 0; weights retained.
REQ-026 Priority: rest > flush > coef_we > sample accept; lower-priority action in the same cycle is dropped (no write, no accept).
REQ-027 No arithmetic in this block; all data paths pass W bits unmodified, no sign extension or truncation.

Reset
REQ-028 rest=1: taps, weights, fill_cnt, win_valid, both sum_valid stages <= 0; state <= FILL.
REQ-029 Reset mid-fill or mid-RUN drops all in-flight windows; sum_valid is 0 in the cycle after rest regardless of pipeline contents.
REQ-030 First accept after rest deassertion is permitted in the first cycle with rest=0.

Verification
REQ-031 Reset, write weights 1,2,3,4 to addr 0..3, stream 10,20,30,40 back-to-back -> win_valid=1 once, win_data={10,20,30,40} (tap0=40), win_weights={4,3,2,1}, sum_valid=1 two cycles later, downstream out=40*1+30*2+20*3+10*4=200.
REQ-032 Continue streaming 50 -> win_data tap0=50, tap3=20; win_valid pulses; fill_cnt stays 4.
REQ-033 in_valid=1 with coef_we=1 same cycle -> in_ready=0, sample not taken, fill_cnt unchanged, weight updated.
REQ-034 flush after 2 samples while win_valid pipeline empty, then 4 samples 1,2,3,4 -> no win_valid until 4th new sample; window {1,2,3,4}, no stale data.
REQ-035 rest asserted one cycle after a win_valid pulse -> sum_valid never asserts for that window; all outputs 0 next cycle.
REQ-036 in_valid gapped (1,0,1,0,...) over 6 samples -> win_valid pulses exactly for samples 4,5,6; sum_valid mirrors each pulse 2 cycles later.
